// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with loadable seed/taps, counted and free-run
// stepping, a busy/done handshake and a wrap pulse when the state returns to the seed.
module lfsr_gen #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(8'h01),
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] tap_in,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             free_run,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t             fsm, fsm_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_nxt;
    logic [WIDTH-1:0] seed, seed_nxt;
    logic [WIDTH-1:0] taps, taps_nxt;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             fb;
    logic             shift;
    logic             done_nxt;
    logic             wrap_nxt;

    // The all-zero term forces a 1 in so a zero state can never lock up.
    always_comb begin
        fb      = (^(lfsr & taps)) ^ (lfsr == '0);
        shifted = {fb, lfsr[WIDTH-1:1]};
    end

    always_comb begin
        fsm_nxt  = fsm;
        lfsr_nxt = lfsr;
        seed_nxt = seed;
        taps_nxt = taps;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        wrap_nxt = 1'b0;
        shift    = 1'b0;

        if (load) begin
            lfsr_nxt = din;
            seed_nxt = din;
            taps_nxt = tap_in;
            fsm_nxt  = IDLE;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start) begin
                        if (steps == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            fsm_nxt = RUN;
                            cnt_nxt = steps;
                        end
                    end else if (free_run) begin
                        shift = 1'b1;
                    end
                end
                RUN: begin
                    shift   = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        fsm_nxt  = IDLE;
                        done_nxt = 1'b1;
                    end
                end
                default: fsm_nxt = IDLE;
            endcase
        end

        // Wrap compares against the seed as it stands before this edge.
        if (shift) begin
            lfsr_nxt = shifted;
            wrap_nxt = (shifted == seed);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm  <= IDLE;
            lfsr <= RESET_SEED;
            seed <= RESET_SEED;
            taps <= TAPS;
            cnt  <= '0;
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            fsm  <= fsm_nxt;
            lfsr <= lfsr_nxt;
            seed <= seed_nxt;
            taps <= taps_nxt;
            cnt  <= cnt_nxt;
            done <= done_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign dout = lfsr;
    assign sout = lfsr[0];
    assign busy = (fsm == RUN);

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed scenarios plus randomized runs
// compared against an arithmetic LFSR reference model.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, start, free_run;
    logic [7:0]  din, tap_in, dout;
    logic [15:0] steps;
    logic        sout, busy, done, wrap;

    logic        load_4, start_4, free_run_4;
    logic [3:0]  din_4, tap_in_4, dout_4;
    logic [15:0] steps_4;
    logic        sout_4, busy_4, done_4, wrap_4;

    int total = 0;
    int bad   = 0;
    int unsigned m_state, m_seed, m_taps, m4;

    lfsr_gen dut (
        .clk(clk), .rst(rst), .load(load), .din(din), .tap_in(tap_in),
        .start(start), .steps(steps), .free_run(free_run),
        .dout(dout), .sout(sout), .busy(busy), .done(done), .wrap(wrap)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .RESET_SEED(4'h1), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .load(load_4), .din(din_4), .tap_in(tap_in_4),
        .start(start_4), .steps(steps_4), .free_run(free_run_4),
        .dout(dout_4), .sout(sout_4), .busy(busy_4), .done(done_4), .wrap(wrap_4)
    );

    always #5 clk = ~clk;

    // Reference step: parity of tapped bits, forced to 1 from the zero state,
    // enters at the top while everything else moves down one place.
    function automatic int unsigned modelStep(int unsigned s, int unsigned t, int w);
        int          ones = 0;
        int unsigned fb;
        for (int i = 0; i < w; i++)
            if ((((s & t) >> i) & 32'd1) != 32'd0) ones++;
        fb = (((ones % 2) == 1) != (s == 32'd0)) ? 32'd1 : 32'd0;
        return (s >> 1) + fb * (32'd1 << (w - 1));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int unsigned e_dout, input bit e_busy,
                            input bit e_done, input bit e_wrap);
        checkOutput({tag, "_dout"}, 32'(dout), e_dout);
        checkOutput({tag, "_sout"}, 32'(sout), e_dout & 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'(e_busy));
        checkOutput({tag, "_done"}, 32'(done), 32'(e_done));
        checkOutput({tag, "_wrap"}, 32'(wrap), 32'(e_wrap));
    endtask

    task automatic applyStimulus(input bit ld, input int unsigned d, input int unsigned tp,
                                 input bit st, input int unsigned stp, input bit fr);
        load     = ld;
        din      = 8'(d);
        tap_in   = 8'(tp);
        start    = st;
        steps    = 16'(stp);
        free_run = fr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first, second, n, idle_n;
        int unsigned d, tp;

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        load_4 = 0; din_4 = '0; tap_in_4 = '0; start_4 = 0; steps_4 = '0; free_run_4 = 0;
        tick();
        rst = 1'b0;
        m_state = 1; m_seed = 1; m_taps = 32'h1D;
        checkAll("rst", 1, 0, 0, 0);
        checkOutput("rst_dout4", 32'(dout_4), 32'h1);

        // Counted run of five shifts from the reset seed
        applyStimulus(0, 0, 0, 1, 5, 0);
        tick();
        checkAll("t1_start", m_state, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            m_state = modelStep(m_state, m_taps, 8);
            checkAll("t1_run", m_state, i < 5, i == 5, m_state == m_seed);
        end
        checkOutput("t1_final", 32'(dout), 32'h88);
        tick();
        checkAll("t1_after", m_state, 0, 0, 0);

        // Zero state escapes
        applyStimulus(1, 0, 32'h1D, 0, 0, 0);
        tick();
        m_state = 0; m_seed = 0; m_taps = 32'h1D;
        checkAll("t2_load", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        tick();
        checkAll("t2_start", 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        m_state = modelStep(m_state, m_taps, 8);
        checkAll("t2_run", m_state, 0, 1, 0);
        checkOutput("t2_escape", 32'(dout), 32'h80);

        // Zero-step start
        applyStimulus(0, 0, 0, 1, 0, 0);
        tick();
        checkAll("t4_start", m_state, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkAll("t4_after", m_state, 0, 0, 0);

        // Free run period
        applyStimulus(1, 1, 32'h1D, 0, 0, 0);
        tick();
        m_state = 1; m_seed = 1; m_taps = 32'h1D;
        checkAll("t3_load", 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        first = -1; second = -1;
        for (int k = 1; k <= 510; k++) begin
            tick();
            m_state = modelStep(m_state, m_taps, 8);
            checkAll("t3_free", m_state, 0, 0, m_state == m_seed);
            if (wrap) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3_first_wrap", 32'(first), 32'd255);
        checkOutput("t3_second_wrap", 32'(second), 32'd510);
        tick();
        checkAll("t3_hold", m_state, 0, 0, 0);

        // Abort by load, with start/free_run ignored mid-run
        applyStimulus(0, 0, 0, 1, 100, 0);
        tick();
        checkAll("t5_start", m_state, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) applyStimulus(0, 0, 0, 1, 3, 1);
            else applyStimulus(0, 0, 0, 0, 0, 0);
            tick();
            m_state = modelStep(m_state, m_taps, 8);
            checkAll("t5_run", m_state, 1, 0, m_state == m_seed);
        end
        applyStimulus(1, 32'hA5, 32'h1D, 0, 0, 0);
        tick();
        m_state = 32'hA5; m_seed = 32'hA5; m_taps = 32'h1D;
        checkAll("t5_abort", 32'hA5, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll("t5_nodone", m_state, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 1, 50, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_state = 1; m_seed = 1; m_taps = 32'h1D;
        checkAll("t5_rst", 1, 0, 0, 0);

        // Randomized loads, runs and idle free-run stretches
        for (int r = 0; r < 6; r++) begin
            d  = $urandom & 32'hFF;
            tp = $urandom & 32'hFF;
            applyStimulus(1, d, tp, 0, 0, 0);
            tick();
            m_state = d; m_seed = d; m_taps = tp;
            checkAll("rnd_load", m_state, 0, 0, 0);
            n = int'($urandom_range(1, 12));
            applyStimulus(0, 0, 0, 1, 32'(n), 0);
            tick();
            checkAll("rnd_start", m_state, 1, 0, 0);
            for (int i = 1; i <= n; i++) begin
                applyStimulus(0, 0, 0, 1'($urandom), $urandom & 32'hF, 1'($urandom));
                tick();
                m_state = modelStep(m_state, m_taps, 8);
                checkAll("rnd_run", m_state, i < n, i == n, m_state == m_seed);
            end
            idle_n = int'($urandom_range(0, 5));
            applyStimulus(0, 0, 0, 0, 0, 1);
            for (int i = 0; i < idle_n; i++) begin
                tick();
                m_state = modelStep(m_state, m_taps, 8);
                checkAll("rnd_free", m_state, 0, 0, m_state == m_seed);
            end
            applyStimulus(0, 0, 0, 0, 0, 0);
            tick();
            checkAll("rnd_hold", m_state, 0, 0, 0);
        end

        // Four-bit instance: period 15, and load beats start
        m4 = 1;
        free_run_4 = 1;
        first = -1; second = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            m4 = modelStep(m4, 32'h3, 4);
            checkOutput("t6_dout4", 32'(dout_4), m4);
            checkOutput("t6_wrap4", 32'(wrap_4), 32'(m4 == 32'd1));
            if (wrap_4) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        checkOutput("t6_first_wrap", 32'(first), 32'd15);
        checkOutput("t6_second_wrap", 32'(second), 32'd30);
        free_run_4 = 0; load_4 = 1; din_4 = 4'h9; tap_in_4 = 4'h3; start_4 = 1; steps_4 = 16'd5;
        tick();
        load_4 = 0; start_4 = 0;
        checkOutput("t6_load_dout4", 32'(dout_4), 32'h9);
        checkOutput("t6_load_busy4", 32'(busy_4), 32'h0);
        tick();
        checkOutput("t6_norun_dout4", 32'(dout_4), 32'h9);
        checkOutput("t6_norun_busy4", 32'(busy_4), 32'h0);
        checkOutput("t6_norun_done4", 32'(done_4), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR. Successor to the fixed 8-bit pattern generator used in the shift-register experiments.
- Adds the following over the fixed generator:
  - generic width;
  - runtime-loadable tap mask;
  - a counted-step run mode with a busy/done handshake;
  - a free-run mode;
  - a serial output;
  - a wrap (period) detector against the loaded seed.
- Drives LED/7-seg pattern demos and supplies pseudo-random stimulus to other lab blocks.

Parameters:
WIDTH, 8, register width in bits (2..32).
TAPS, 8'h1D, reset-time tap mask; bit i set means state[i] feeds the XOR. Width is WIDTH.
RESET_SEED, 8'h01, state and seed register value after reset. Width is WIDTH.
CNT_W, 16, width of the step-count input and internal step counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
load  in  1  load state from din, seed from din, taps from tap_in.
din  in  WIDTH  seed/state value for load.
tap_in  in  WIDTH  tap mask latched on load.
start  in  1  begin a counted run of `steps` shifts.
steps  in  CNT_W  number of shifts for a counted run; sampled with start.
free_run  in  1  level; while high and idle, shift every cycle.
dout  out  WIDTH  current LFSR state.
sout  out  1  state[0], the bit being shifted out this cycle.
busy  out  1  high while a counted run is in progress.
done  out  1  one-cycle pulse when a counted run completes.
wrap  out  1  one-cycle pulse: the state produced by a shift equals the seed register.

Behaviour:
Feedback and shift
- fb = XOR-reduce(state & taps) XOR (state == 0).
- One shift: state <= {fb, state[WIDTH-1:1]}.
- All-zero state is never stuck: 0 -> {1, 0...0}.

Reset (rst high at an edge)
- state = RESET_SEED, seed = RESET_SEED, taps = TAPS, cnt = 0.
- FSM = IDLE; busy = 0, done = 0, wrap = 0.
- rst overrides every other input, including in mid-run.

Priority per edge: rst > load > start > run/free-run shift > hold.

FSM states: IDLE, RUN.
- IDLE + load:
  - state <= din, seed <= din, taps <= tap_in; no shift.
  - wrap = 0 and done = 0 on that edge.
- IDLE + start, steps = 0: stay IDLE, no shift, done = 1 for the next cycle.
- IDLE + start, steps = N > 0: go to RUN, cnt <= N, busy = 1; no shift on the start edge.
- IDLE + free_run (no load/start): one shift per cycle; busy stays 0.
- RUN, each edge:
  - one shift; cnt decrements.
  - On the edge where cnt goes 1 -> 0: FSM = IDLE, busy = 0, done = 1 for exactly one cycle.
  - Exactly N shifts occur; the final state is visible on dout the same cycle done is high.
- RUN + load:
  - load is applied (state, seed, taps replaced) and the run is aborted: FSM = IDLE, busy = 0.
  - No done pulse.
- RUN + start: ignored.
- RUN + free_run: ignored until the run ends.

Output timing
- dout and sout are the registered state; no combinational path from inputs.
- wrap is registered. It is high for the cycle after any shift whose new state equals seed.
- wrap is never asserted by a load or by rst.
- done and wrap can be high in the same cycle.

Arithmetic and widths
- cnt is an unsigned CNT_W down-counter.
- steps is sampled only on an accepted start.
- Changes to tap_in outside load have no effect.

Test Plan:
1. WIDTH=8 defaults. rst, then start steps=5 -> busy high 5 cycles; dout sequence 0x80, 0x40, 0x20, 0x10, 0x88; done pulses once with dout=0x88; busy=0 after.
2. load din=0x00 tap_in=0x1D, then start steps=1 -> dout=0x80, done=1. Zero-lock escape confirmed.
3. load din=0x01, then free_run=1 -> first wrap pulse exactly 255 shifts after the load; dout=0x01 in that cycle; next wrap 255 shifts later.
4. start steps=0 -> no shift, busy stays 0, done pulses one cycle after start, dout unchanged.
5. start steps=100; after 10 shifts assert load din=0xA5 -> dout=0xA5 next cycle, busy=0, no done pulse. Then assert rst mid-way through a new run -> dout=0x01, busy=0, done=0, wrap=0.
6. Reparametrise WIDTH=4, TAPS=4'h3, RESET_SEED=4'h1; free_run from reset -> wrap every 15 shifts. Also assert start and load on the same edge -> load wins, no run starts.
